// File: rtl/ysyx_22050710_fetch_queue_if.sv
// Fetch-to-decode queue interface: fetch-side offer, decode-side head, flush and occupancy.
// master = the fetch/decode environment driving the queue; slave = the queue itself.
interface ysyx_22050710_fetch_queue_if #(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 64,
   parameter int INST_W = 32
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              i_flush;
   logic              i_in_valid;
   logic              o_in_ready;
   logic [PC_W-1:0]   i_in_pc;
   logic [INST_W-1:0] i_in_inst;
   logic              o_out_valid;
   logic              i_out_ready;
   logic [PC_W-1:0]   o_out_pc;
   logic [INST_W-1:0] o_out_inst;
   logic [CW-1:0]     o_count;

   modport master (
      output i_flush, i_in_valid, i_in_pc, i_in_inst, i_out_ready,
      input  o_in_ready, o_out_valid, o_out_pc, o_out_inst, o_count
   );

   modport slave (
      input  i_flush, i_in_valid, i_in_pc, i_in_inst, i_out_ready,
      output o_in_ready, o_out_valid, o_out_pc, o_out_inst, o_count
   );
endinterface

// File: rtl/ysyx_22050710_fetch_queue.sv
// Circular {pc, inst} queue between fetch and decode, flushed on redirect.
// Optional zero-latency empty-queue pass-through: define YSYX_22050710_FETCH_QUEUE_BYPASS_EN.
module ysyx_22050710_fetch_queue #(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 64,
   parameter int INST_W = 32
) (
   input logic i_clk,
   input logic i_rst,
   ysyx_22050710_fetch_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]       wptr;
   logic [AW:0]       rptr;
   logic [PC_W-1:0]   pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];

   logic empty;
   logic full;
   logic push_en;
   logic pop_en;
   logic bypass_hit;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

`ifdef YSYX_22050710_FETCH_QUEUE_BYPASS_EN
   // An offer into an empty queue with decode ready goes straight out and is never stored.
   assign bypass_hit = empty & bus.i_in_valid & bus.i_out_ready & ~bus.i_flush;
`else
   assign bypass_hit = 1'b0;
`endif

   assign bus.o_in_ready  = ~full & ~bus.i_flush;
   assign bus.o_out_valid = (~empty & ~bus.i_flush) | bypass_hit;
   assign push_en         = bus.i_in_valid & bus.o_in_ready & ~bypass_hit;
   assign pop_en          = ~empty & ~bus.i_flush & bus.i_out_ready;
   assign bus.o_count     = wptr - rptr;

   always_comb begin
      bus.o_out_pc   = '0;
      bus.o_out_inst = '0;
      if (bypass_hit) begin
         bus.o_out_pc   = bus.i_in_pc;
         bus.o_out_inst = bus.i_in_inst;
      end else if (!empty) begin
         bus.o_out_pc   = pc_mem[rptr[AW-1:0]];
         bus.o_out_inst = inst_mem[rptr[AW-1:0]];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wptr <= '0;
         rptr <= '0;
      end else if (bus.i_flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push_en) wptr <= wptr + (AW+1)'(1);
         if (pop_en)  rptr <= rptr + (AW+1)'(1);
      end
   end

   // Storage is deliberately left unreset; only the pointers define what is valid.
   always_ff @(posedge i_clk) begin
      if (push_en) begin
         pc_mem[wptr[AW-1:0]]   <= bus.i_in_pc;
         inst_mem[wptr[AW-1:0]] <= bus.i_in_inst;
      end
   end
endmodule

// File: doc/ysyx_22050710_fetch_queue.md
# ysyx_22050710_fetch_queue

Instruction queue between the instruction fetch unit and the decoder of the ysyx_22050710 core. It buffers up to DEPTH fetched {pc, inst} pairs behind a valid/ready handshake on each side, so fetch can run ahead of a stalled decoder. A redirect (taken branch, jump, trap) flushes all buffered entries.

## Interface
- DEPTH, 4, number of entries; power of 2, ≥ 2
- PC_W, 64, PC width
- INST_W, 32, instruction width

- i_clk  input  1  clock; all state updates on the rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_flush  input  1  redirect; discard every buffered and in-flight entry
- i_in_valid  input  1  fetch offers an entry
- o_in_ready  output  1  queue accepts an entry
- i_in_pc  input  PC_W  PC of the offered instruction
- i_in_inst  input  INST_W  offered instruction word
- o_out_valid  output  1  head entry valid for decode
- i_out_ready  input  1  decoder consumes the head
- o_out_pc  output  PC_W  head PC
- o_out_inst  output  INST_W  head instruction
- o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Circular buffer; write pointer wptr and read pointer rptr are each $clog2(DEPTH)+1 bits wide, with the MSB as the wrap bit.
- Empty when wptr == rptr. Full when the low bits are equal and the MSBs differ.
- o_count = wptr − rptr, modulo 2^($clog2(DEPTH)+1).
- Push happens when i_in_valid & o_in_ready. Pop happens when o_out_valid & i_out_ready.
- o_in_ready = !full & !i_flush. Ready does not depend on i_out_ready, so a full queue never accepts a push, even in a cycle where it pops.
- o_out_valid = !empty & !i_flush. On a pop, o_out_pc/o_out_inst carry mem[rptr]. When empty, both are driven to 0.
- Simultaneous push and pop: both pointers advance and o_count is unchanged.
- Pointer wrap-around is natural binary overflow. No special casing.
- i_flush has the highest priority. In the flush cycle, no push or pop occurs. Next edge: wptr = rptr = 0, o_count = 0.
- Storage array is not reset. Only pointers are reset.

## Timing
- Reset values: wptr = rptr = 0, o_count = 0, o_out_valid = 0, o_out_pc = 0, o_out_inst = 0, o_in_ready = 1.
- Reset asserted mid-operation clears the queue immediately, without waiting for a clock edge. Entries are lost and nothing is popped afterward.
- Latency: an entry pushed at edge N appears at the head from cycle N+1 (bypass disabled).
- Throughput: 1 push and 1 pop per cycle sustained.
- The first push after a flush may occur in the cycle after the flush cycle.
- o_in_ready and o_out_valid depend combinationally only on pointer state and i_flush, except under bypass (see Configuration).

## Configuration
- Macro: YSYX_22050710_FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When the queue is empty, i_in_valid = 1, i_out_ready = 1 and i_flush = 0, the input passes straight through: o_out_valid = 1, o_out_pc = i_in_pc, o_out_inst = i_in_inst.
  - Nothing is written and o_count stays 0, giving zero-cycle latency.
  - If the queue is empty but i_out_ready = 0, the entry is written normally.
  - This creates a combinational in→out path that integration must time.
- Undefined: no combinational path from the input side to the output side. Latency is fixed at 1 cycle.

## Test plan
- Reset then idle: after i_rst is released, o_count = 0, o_out_valid = 0, o_in_ready = 1. Assert i_rst mid-stream with 3 entries queued: o_count drops to 0 with no clock edge.
- Fill/drain, DEPTH = 4, i_out_ready = 0: push PCs 0x80000000, 0x80000004, 0x80000008, 0x8000000c.
  - After the 4th push: o_in_ready = 0 and o_count = 4. A 5th push is refused.
  - Then with i_out_ready = 1, pops return the same PCs in order, and o_count reaches 0.
- Streaming wrap: 10 consecutive push+pop cycles with both sides always ready and PCs incrementing by 4.
  - Without bypass, o_count stays 1 after the first push, and output order is exact across pointer wrap.
- Full with pop: at o_count = 4, i_in_valid = 1, i_out_ready = 1.
  - The head pops, the push is refused (o_in_ready = 0), and o_count becomes 3.
- Flush: with 3 entries queued, assert i_flush for one cycle while i_in_valid = 1.
  - In that cycle o_out_valid = 0 and o_in_ready = 0. Next cycle o_count = 0, and the pending input was not stored.
- Bypass (macro defined): empty queue, i_in_valid = 1, i_in_pc = 0x80000010, i_in_inst = 0x00000013, i_out_ready = 1.
  - In the same cycle o_out_valid = 1, o_out_pc = 0x80000010, o_out_inst = 0x00000013, and o_count stays 0.
  - Repeat with i_out_ready = 0: o_count becomes 1.
